// File: rtl/exp_feeder.sv
// Sample FIFO feeding a multi-cycle exponential core one argument at a time,
// holding each result until downstream takes it. Optional watchdog: EXP_FEEDER_TIMEOUT_EN.
module exp_feeder #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  output logic        core_start,
  output logic [15:0] core_x,
  input  logic        core_done,
  input  logic [1:0]  core_intpart,
  input  logic [15:0] core_fracpart,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_intpart,
  output logic [15:0] out_fracpart,
  output logic        out_err,
  output logic        busy,
  output logic [1:0]  dbg_state
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never waits on ready, and held data stays stable until the transfer.

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("exp_feeder: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  state_t        state_q, state_d;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          core_start_q, core_start_d;
  logic [15:0]   core_x_q, core_x_d;
  logic          out_valid_q, out_valid_d;
  logic [1:0]    int_q, int_d;
  logic [15:0]   frac_q, frac_d;
  logic          busy_q, busy_d;
  logic          push, pop;

`ifdef EXP_FEEDER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
  logic          err_q, err_d;
`endif

  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  // The FIFO head is consumed only when the FSM launches it from IDLE.
  assign pop      = (state_q == S_IDLE) && (count_q != '0);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    core_start_d = 1'b0;
    core_x_d     = core_x_q;
    out_valid_d  = out_valid_q;
    int_d        = int_q;
    frac_d       = frac_q;
`ifdef EXP_FEEDER_TIMEOUT_EN
    wd_d         = wd_q;
    err_d        = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d      = S_LAUNCH;
          core_x_d     = mem_q[rd_ptr_q];
          core_start_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
`ifdef EXP_FEEDER_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      S_WAIT: begin
        if (core_done) begin
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
          int_d       = core_intpart;
          frac_d      = core_fracpart;
`ifdef EXP_FEEDER_TIMEOUT_EN
          err_d       = 1'b0;
        end else if (wd_q == WW'(TIMEOUT)) begin
          state_d     = S_HOLD;
          out_valid_d = 1'b1;
          int_d       = '0;
          frac_d      = '0;
          err_d       = 1'b1;
        end else begin
          wd_d        = wd_q + 1'b1;
`endif
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      core_start_q <= 1'b0;
      core_x_q     <= '0;
      out_valid_q  <= 1'b0;
      int_q        <= '0;
      frac_q       <= '0;
      busy_q       <= 1'b0;
`ifdef EXP_FEEDER_TIMEOUT_EN
      wd_q         <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      core_start_q <= core_start_d;
      core_x_q     <= core_x_d;
      out_valid_q  <= out_valid_d;
      int_q        <= int_d;
      frac_q       <= frac_d;
      busy_q       <= busy_d;
`ifdef EXP_FEEDER_TIMEOUT_EN
      wd_q         <= wd_d;
      err_q        <= err_d;
`endif
    end
  end

  // Storage needs no reset: occupancy alone says which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_x;
  end

  assign core_start   = core_start_q;
  assign core_x       = core_x_q;
  assign out_valid    = out_valid_q;
  assign out_intpart  = int_q;
  assign out_fracpart = frac_q;
  assign busy         = busy_q;
  assign dbg_state    = state_q;
`ifdef EXP_FEEDER_TIMEOUT_EN
  assign out_err      = err_q;
`else
  assign out_err      = 1'b0;
`endif

endmodule

// File: tb/tb_exp_feeder.sv
// Bench for exp_feeder: transaction-level model of the feeder plus a simple core
// model, checked every cycle, with directed scenarios and randomized traffic.
module tb_exp_feeder;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic        core_start;
  logic [15:0] core_x;
  logic        core_done;
  logic [1:0]  core_intpart;
  logic [15:0] core_fracpart;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [1:0]  out_intpart;
  logic [15:0] out_fracpart;
  logic        out_err;
  logic        busy;
  logic [1:0]  dbg_state;

  int checks = 0;
  int fails  = 0;

  exp_feeder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .core_start(core_start), .core_x(core_x), .core_done(core_done),
    .core_intpart(core_intpart), .core_fracpart(core_fracpart),
    .out_valid(out_valid), .out_ready(out_ready), .out_intpart(out_intpart),
    .out_fracpart(out_fracpart), .out_err(out_err), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #(10 * 90000);
    $display("FAIL global_timeout: simulation did not finish (got hang, required finish)");
    $fatal(1, "global timeout");
  end

  // ---------------- core model ----------------
  function automatic logic [17:0] core_fn(input logic [15:0] x);
    if (x == 16'h8000) return {2'd1, 16'h8AC7};
    return {x[15:14], x ^ 16'h5A5A};
  endfunction

  logic        m_done = 1'b0;
  logic [1:0]  m_int = '0;
  logic [15:0] m_frac = '0;
  logic        spur = 1'b0;
  int          core_delay = 3;
  bit          rand_delay = 1'b0;
  bit          core_stall = 1'b0;

  assign core_done     = m_done | spur;
  assign core_intpart  = spur ? 2'd3 : m_int;
  assign core_fracpart = spur ? 16'hFFFF : m_frac;

  initial begin
    forever begin
      @(negedge clk);
      if (core_start) begin
        int d;
        d = rand_delay ? int'($urandom_range(1, 8)) : core_delay;
        repeat (d) @(negedge clk);
        while (core_stall) @(negedge clk);
        {m_int, m_frac} = core_fn(core_x);
        m_done = 1'b1;
        @(negedge clk);
        m_done = 1'b0;
      end
    end
  end

  bit rand_or  = 1'b0;
  bit or_level = 1'b1;
  always @(negedge clk) out_ready = rand_or ? 1'($urandom_range(0, 1)) : or_level;

  // ---------------- reference model ----------------
  // phase: 0 free, 1 start cycle, 2 core computing, 3 result presented
  logic [15:0] pend_q[$];
  logic [15:0] svc_x = '0;
  int          phase = 0;
  int          wcnt = 0;
  logic [17:0] res = '0;
  logic        res_err = 1'b0;
  int          pushes_seen = 0;
  int          starts_seen = 0;
  int          results_seen = 0;

  always @(posedge clk) begin
    if (!rst) begin
      pend_q.delete();
      phase = 0;
      svc_x = '0;
      wcnt  = 0;
    end else begin
      case (phase)
        0: if (pend_q.size() > 0) begin
             svc_x = pend_q.pop_front();
             phase = 1;
             starts_seen++;
           end
        1: begin phase = 2; wcnt = 0; end
        2: if (core_done) begin
             res = core_fn(svc_x);
             res_err = 1'b0;
             phase = 3;
           end else begin
`ifdef EXP_FEEDER_TIMEOUT_EN
             wcnt++;
             if (wcnt > TIMEOUT) begin
               res = '0;
               res_err = 1'b1;
               phase = 3;
             end
`endif
           end
        3: if (out_ready) begin phase = 0; results_seen++; end
        default: phase = 0;
      endcase
      if (in_valid && in_ready) begin
        pend_q.push_back(in_x);
        pushes_seen++;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
    end
  endtask

  task automatic fail_wait(input string name);
    checks++;
    fails++;
    $display("FAIL %s at %0t: got no event, required event within bound", name, $time);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("rst_core_start", core_start, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_err", out_err, 0);
      check("rst_busy", busy, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_core_x", core_x, 0);
      check("rst_out_int", out_intpart, 0);
      check("rst_out_frac", out_fracpart, 0);
    end else begin
      check("core_start", core_start, phase == 1);
      check("in_ready", in_ready, pend_q.size() < DEPTH);
      check("busy", busy, (phase != 0) || (pend_q.size() != 0));
      check("out_valid", out_valid, phase == 3);
      if (phase == 1 || phase == 2) check("core_x", core_x, svc_x);
      if (phase == 3) begin
        check("out_intpart", out_intpart, res[17:16]);
        check("out_fracpart", out_fracpart, res[15:0]);
        check("out_err", out_err, res_err);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [15:0] x);
    int  n;
    bit  acc;
    n = 0;
    in_valid = 1'b1;
    in_x = x;
    forever begin
      acc = in_ready;
      @(negedge clk);
      if (acc) break;
      n++;
      if (n > 400) begin fail_wait("push_accept"); break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!core_start) begin
      @(negedge clk);
      n++;
      if (n > 200) begin fail_wait("core_start_wait"); return; end
    end
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!out_valid) begin
      @(negedge clk);
      n++;
      if (n > 300) begin fail_wait("out_valid_wait"); return; end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (phase != 0 || pend_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 3000) begin fail_wait("drain_wait"); return; end
    end
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  bit fill_done = 1'b0;

  initial begin
    int sbase, rbase, pbase, n;

    repeat (3) @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    #1 rst = 1'b1;
    @(negedge clk);

    // single sample with a 10-cycle core
    core_delay = 10;
    sbase = starts_seen;
    push(16'h8000);
    check("latency_idle_cycle", core_start, 0);
    @(negedge clk);
    check("latency_start", core_start, 1);
    check("single_core_x", core_x, 16'h8000);
    wait_valid();
    check("single_int", out_intpart, 2'd1);
    check("single_frac", out_fracpart, 16'h8AC7);
    check("single_err", out_err, 0);
    wait_drain();
    check("single_start_count", starts_seen - sbase, 1);

    // fill the FIFO while the core is stalled
    core_delay = 2;
    core_stall = 1'b1;
    pbase = pushes_seen;
    rbase = results_seen;
    fork
      begin
        for (int i = 0; i < 6; i++) push(16'hA000 + 16'(i));
        fill_done = 1'b1;
      end
    join_none
    repeat (12) @(negedge clk);
    check("fill_accepted", pushes_seen - pbase, 5);
    check("fill_in_ready_low", in_ready, 0);
    core_stall = 1'b0;
    n = 0;
    while ((results_seen - rbase) < 6 && n < 500) begin @(negedge clk); n++; end
    check("fill_results", results_seen - rbase, 6);
    check("fill_push_finished", fill_done, 1);
    wait_drain();

    // backpressure in HOLD
    or_level = 1'b0;
    core_delay = 3;
    @(negedge clk);
    push(16'h1234);
    push(16'h4321);
    wait_valid();
    sbase = starts_seen;
    repeat (20) @(negedge clk);
    check("bp_no_start", starts_seen - sbase, 0);
    check("bp_valid_held", out_valid, 1);
    check("bp_int", out_intpart, 2'd0);
    check("bp_frac", out_fracpart, 16'h486E);
    or_level = 1'b1;
    wait_drain();

    // spurious done in IDLE and in LAUNCH
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    check("spur_idle_no_valid", out_valid, 0);
    core_delay = 6;
    push(16'hC0DE);
    wait_start();
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check("spur_launch_no_valid", out_valid, 0);
    check("spur_launch_core_x", core_x, 16'hC0DE);
    wait_drain();

    // reset while the core is computing
    core_delay = 15;
    push(16'hD00D);
    wait_start();
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (20) @(negedge clk);
    check("rstwait_no_valid", out_valid, 0);
    check("rstwait_busy", busy, 0);
    check("rstwait_in_ready", in_ready, 1);
    check("rstwait_core_x", core_x, 0);
    check("rstwait_frac", out_fracpart, 0);

    // randomized traffic
    rand_delay = 1'b1;
    rand_or = 1'b1;
    rbase = results_seen;
    for (int i = 0; i < 40; i++) begin
      push(16'($urandom_range(0, 65535)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    rand_or = 1'b0;
    or_level = 1'b1;
    wait_drain();
    check("rand_result_count", results_seen - rbase, 40);
    rand_delay = 1'b0;

`ifdef EXP_FEEDER_TIMEOUT_EN
    // core never answers: watchdog produces an error result
    core_stall = 1'b1;
    push(16'h0BAD);
    wait_start();
    @(negedge clk);
    check("to_start_fell", core_start, 0);
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    check("to_latency", n, TIMEOUT + 1);
    check("to_err", out_err, 1);
    check("to_int", out_intpart, 0);
    check("to_frac", out_fracpart, 0);
    repeat (3) @(negedge clk);
    core_stall = 1'b0;
    repeat (5) @(negedge clk);
    core_delay = 4;
    push(16'h8000);
    wait_valid();
    check("to_next_err", out_err, 0);
    check("to_next_frac", out_fracpart, 16'h8AC7);
    wait_drain();
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
